// File: rtl/seq_log_pkg.sv
// Shared widths and the log entry layout for the sequence-detection event logger.
package seq_log_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned TS_W   = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DEPTH  = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] lfsr;
    } log_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with exact level count and a synchronous clear.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/seq_event_logger.sv
// Counts rising detections of the target sequence and logs {timestamp, LFSR state}
// for each into a FWFT FIFO drained by a valid/ready reader.
module seq_event_logger #(
    parameter int unsigned DATA_W = seq_log_pkg::DATA_W,
    parameter int unsigned TS_W   = seq_log_pkg::TS_W,
    parameter int unsigned CNT_W  = seq_log_pkg::CNT_W,
    parameter int unsigned DEPTH  = seq_log_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      lfsr_reg,
    input  logic                   seq_detected,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [TS_W+DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]       det_count,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    import seq_log_pkg::*;

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             seq_prev_q;
    logic             evt, pop, push, drop;
    logic             fifo_full, fifo_empty;

    assign evt      = en & seq_detected & ~seq_prev_q;
    assign rd_valid = ~fifo_empty;
    assign pop      = rd_valid & rd_ready;
    assign push     = evt & (~fifo_full | pop);
    assign drop     = evt & fifo_full & ~pop;

    // clr wins over counting, dropping and the timestamp advance.
    always_comb begin
        ts_d  = ts_q + TS_W'(1);
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            ts_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (evt && cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            seq_prev_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            seq_prev_q <= seq_detected;
        end
    end

    sync_fifo #(
        .WIDTH (TS_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({ts_q, lfsr_reg}),
        .rdata_o (rd_data),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign det_count = cnt_q;
    assign overflow  = ovf_q;

endmodule
